// File: rtl/stdout_fifo.sv
// First-word-fall-through byte FIFO from the CPU stdout path to the UART transmit side.
// Define STDOUT_FIFO_STATS_EN to add saturating written/dropped byte counters.
module stdout_fifo #(
  parameter int DEPTH_LOG2         = 10,
  parameter int ALMOST_FULL_MARGIN = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_write_enable,
  input  logic [7:0]            cpu_write_data,
  output logic                  cpu_write_ready,
  input  logic                  stdout_memory_read_enable,
  output logic                  stdout_memory_read_ready,
  output logic [7:0]            stdout_memory_read_data,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  almost_full,
  output logic                  overflow,
`ifdef STDOUT_FIFO_STATS_EN
  output logic [31:0]           stat_bytes_written,
  output logic [31:0]           stat_bytes_dropped,
`endif
  input  logic                  clear_overflow
);

  localparam int LW = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] DEPTH_L    = LW'(1 << DEPTH_LOG2);
  localparam logic [DEPTH_LOG2:0] AF_THRESH  = LW'((1 << DEPTH_LOG2) - ALMOST_FULL_MARGIN);
  localparam logic [DEPTH_LOG2:0] LEVEL_ZERO = LW'(0);
  localparam logic [DEPTH_LOG2:0] LEVEL_ONE  = LW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  logic [7:0]            mem_q [0:(1 << DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;
  logic                  push_ok_s, pop_ok_s, reject_s;

  // Handshake acceptance; a full FIFO still takes a push when a pop frees a slot the same cycle.
  always_comb begin
    pop_ok_s  = stdout_memory_read_enable && (level_q != LEVEL_ZERO);
    push_ok_s = cpu_write_enable && ((level_q < DEPTH_L) || pop_ok_s);
    reject_s  = cpu_write_enable && !push_ok_s;
  end

  // Next-state for pointers, occupancy and the sticky overflow flag (set beats clear).
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
    if (reject_s) begin
      overflow_d = 1'b1;
    end else if (clear_overflow) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers; buffered bytes are discarded by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage write port; the array is deliberately left unreset so it maps to distributed RAM.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q] <= cpu_write_data;
    end
  end

  // Status and head byte come only from registered state.
  always_comb begin
    cpu_write_ready          = (level_q != DEPTH_L);
    stdout_memory_read_ready = (level_q != LEVEL_ZERO);
    level                    = level_q;
    almost_full              = (level_q >= AF_THRESH);
    overflow                 = overflow_q;
    if (level_q != LEVEL_ZERO) begin
      stdout_memory_read_data = mem_q[rd_ptr_q];
    end else begin
      stdout_memory_read_data = 8'h00;
    end
  end

`ifdef STDOUT_FIFO_STATS_EN
  logic [31:0] stat_written_q, stat_written_d;
  logic [31:0] stat_dropped_q, stat_dropped_d;

  // Saturating traffic counters, independent of clear_overflow.
  always_comb begin
    stat_written_d = stat_written_q;
    stat_dropped_d = stat_dropped_q;
    if (push_ok_s && (stat_written_q != 32'hFFFF_FFFF)) begin
      stat_written_d = stat_written_q + 32'd1;
    end else begin
      stat_written_d = stat_written_q;
    end
    if (reject_s && (stat_dropped_q != 32'hFFFF_FFFF)) begin
      stat_dropped_d = stat_dropped_q + 32'd1;
    end else begin
      stat_dropped_d = stat_dropped_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_written_q <= 32'd0;
      stat_dropped_q <= 32'd0;
    end else begin
      stat_written_q <= stat_written_d;
      stat_dropped_q <= stat_dropped_d;
    end
  end

  assign stat_bytes_written = stat_written_q;
  assign stat_bytes_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_stdout_fifo.sv
// Scoreboard bench for stdout_fifo at depth 4, almost-full margin 1.
module tb_stdout_fifo;

  logic       clk;
  logic       reset_n;
  logic       cpu_write_enable;
  logic [7:0] cpu_write_data;
  logic       cpu_write_ready;
  logic       stdout_memory_read_enable;
  logic       stdout_memory_read_ready;
  logic [7:0] stdout_memory_read_data;
  logic [2:0] level;
  logic       almost_full;
  logic       overflow;
  logic       clear_overflow;
`ifdef STDOUT_FIFO_STATS_EN
  logic [31:0] stat_bytes_written;
  logic [31:0] stat_bytes_dropped;
`endif

  int tests_run;
  int tests_failed;
  logic [7:0] sb_q[$];
  logic       m_ovf;

  stdout_fifo #(.DEPTH_LOG2(2), .ALMOST_FULL_MARGIN(1)) dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .cpu_write_enable          (cpu_write_enable),
    .cpu_write_data            (cpu_write_data),
    .cpu_write_ready           (cpu_write_ready),
    .stdout_memory_read_enable (stdout_memory_read_enable),
    .stdout_memory_read_ready  (stdout_memory_read_ready),
    .stdout_memory_read_data   (stdout_memory_read_data),
    .level                     (level),
    .almost_full               (almost_full),
    .overflow                  (overflow),
`ifdef STDOUT_FIFO_STATS_EN
    .stat_bytes_written        (stat_bytes_written),
    .stat_bytes_dropped        (stat_bytes_dropped),
`endif
    .clear_overflow            (clear_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every status output against the scoreboard's view of the FIFO.
  task automatic check_status(input string tag);
    int n;
    logic [7:0] head;
    n = sb_q.size();
    head = (n > 0) ? sb_q[0] : 8'h00;
    check({tag, ".level"}, 32'(level), 32'(n));
    check({tag, ".wr_rdy"}, 32'(cpu_write_ready), (n < 4) ? 32'd1 : 32'd0);
    check({tag, ".rd_rdy"}, 32'(stdout_memory_read_ready), (n > 0) ? 32'd1 : 32'd0);
    check({tag, ".data"}, 32'(stdout_memory_read_data), 32'(head));
    check({tag, ".afull"}, 32'(almost_full), (n >= 3) ? 32'd1 : 32'd0);
    check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  // One clock cycle of stimulus; pop data is captured before the edge, as the controller would.
  task automatic cycle(input string tag, input logic we, input logic [7:0] wd,
                       input logic re, input logic clr);
    logic pop_ok, push_ok;
    logic [7:0] exp_b;
    cpu_write_enable          = we;
    cpu_write_data            = wd;
    stdout_memory_read_enable = re;
    clear_overflow            = clr;
    #1;
    pop_ok  = re && (sb_q.size() > 0);
    push_ok = we && ((sb_q.size() < 4) || pop_ok);
    if (pop_ok) begin
      exp_b = sb_q.pop_front();
      check({tag, ".pop"}, 32'(stdout_memory_read_data), 32'(exp_b));
    end
    if (push_ok) sb_q.push_back(wd);
    if (we && !push_ok) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    @(posedge clk);
    #1;
    cpu_write_enable          = 1'b0;
    stdout_memory_read_enable = 1'b0;
    clear_overflow            = 1'b0;
    check_status(tag);
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    m_ovf = 1'b0;
    reset_n = 1'b0;
    cpu_write_enable = 1'b0;
    cpu_write_data = 8'h00;
    stdout_memory_read_enable = 1'b0;
    clear_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check_status("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    cycle("push41", 1'b1, 8'h41, 1'b0, 1'b0);
    check("push41.data_lit", 32'(stdout_memory_read_data), 32'h41);
    cycle("pop41", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("full.level", 32'(level), 32'd4);
    cycle("ovf05", 1'b1, 8'h05, 1'b0, 1'b0);
    check("ovf05.lit", 32'(overflow), 32'd1);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    cycle("clr_ovf", 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_ovf.lit", 32'(overflow), 32'd0);

    for (int i = 1; i <= 4; i++) cycle("fill2", 1'b1, 8'(i), 1'b0, 1'b0);
    cycle("fullpp", 1'b1, 8'hAA, 1'b1, 1'b0);
    check("fullpp.level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    cycle("empty_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("emptypp", 1'b1, 8'h77, 1'b1, 1'b0);
    cycle("emptypp_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 10; i++) begin
      cycle("stream", 1'b1, 8'(i + 8'h10), 1'b1, 1'b0);
      check("stream.lvl_max", (level <= 3'd1) ? 32'd1 : 32'd0, 32'd1);
    end
    cycle("stream_end", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) cycle("fill3", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cycle("setwins", 1'b1, 8'hEE, 1'b0, 1'b1);
    check("setwins.lit", 32'(overflow), 32'd1);
    cycle("pop_one", 1'b0, 8'h00, 1'b1, 1'b0);

    reset_n = 1'b0;
    #1;
    sb_q.delete();
    m_ovf = 1'b0;
    check("areset.level", 32'(level), 32'd0);
    check("areset.rd_rdy", 32'(stdout_memory_read_ready), 32'd0);
    check("areset.data", 32'(stdout_memory_read_data), 32'h00);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_status("post_reset");

`ifdef STDOUT_FIFO_STATS_EN
    for (int i = 0; i < 5; i++) cycle("stats", 1'b1, 8'(8'h50 + i), 1'b0, 1'b0);
    check("stats.written", stat_bytes_written, 32'd4);
    check("stats.dropped", stat_bytes_dropped, 32'd1);
    cycle("stats_clr", 1'b0, 8'h00, 1'b0, 1'b1);
    check("stats.dropped_kept", stat_bytes_dropped, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/stdout_fifo.md
Name: stdout_fifo

Overview:
- Byte FIFO between the CPU core's stdout path and the UART controller's transmit side.
- CPU side pushes output bytes; the UART controller pops them through its stdout read handshake (ready / data / enable).
- First-word-fall-through: the head byte is presented combinationally whenever the FIFO is non-empty, so the controller can capture data in the same cycle it asserts the pop.
- Sits directly upstream of the UART controller's stdout transmit logic.

Parameters:
- DEPTH_LOG2, 10, log2 of FIFO depth in bytes (depth = 2**DEPTH_LOG2; legal range 2..12).
- ALMOST_FULL_MARGIN, 16, almost_full asserts when free entries <= this value (must be < depth).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cpu_write_enable  in  1  push request from CPU (one byte per cycle).
- cpu_write_data  in  8  byte to push.
- cpu_write_ready  out  1  1 when not full.
- stdout_memory_read_enable  in  1  pop strobe from UART controller.
- stdout_memory_read_ready  out  1  1 when not empty.
- stdout_memory_read_data  out  8  head byte; 8'h00 when empty.
- level  out  DEPTH_LOG2+1  current occupancy, 0..depth.
- almost_full  out  1  level >= depth - ALMOST_FULL_MARGIN.
- overflow  out  1  sticky; set by a push attempted while full and not accepted.
- clear_overflow  in  1  synchronous clear of overflow.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - Pointers and level go to 0; overflow goes to 0.
  - Outputs: cpu_write_ready=1, stdout_memory_read_ready=0, read_data=8'h00, almost_full=0.
  - Storage array is not reset.
- Reset mid-operation discards all buffered bytes immediately.
- Storage: 2**DEPTH_LOG2 x 8 array.
  - Write port is synchronous.
  - Read is combinational from mem[rd_ptr], gated to 0 when empty (distributed RAM).
- Pointers: wr_ptr and rd_ptr are DEPTH_LOG2 bits wide and wrap modulo depth naturally. level is tracked as a separate counter.
- Push accepted iff cpu_write_enable && (level < depth || pop accepted same cycle). On acceptance: mem[wr_ptr] <= data, wr_ptr++.
- Pop accepted iff stdout_memory_read_enable && level > 0. On acceptance: rd_ptr++.
- Pop while empty is ignored, with no state change.
- Level update:
  - push only: +1.
  - pop only: -1.
  - both: unchanged.
  - neither: unchanged.
- Simultaneous push and pop when full: both accepted; level stays at depth; cpu_write_ready remains 0 that cycle (it is a function of level only).
- Simultaneous push and pop when empty: only the push is accepted; level becomes 1. The popped byte is not the new byte.
- Latency:
  - A pushed byte is visible on read_data and read_ready is 1 the cycle after acceptance.
  - After a pop, the next head is visible the following cycle.
- Overflow:
  - Set on cycle N+1 if a push was rejected on cycle N (full, no pop).
  - The rejected byte is dropped.
  - clear_overflow clears it; if clear and a new rejection happen together, set wins.
- All status outputs are derived from registered level/pointers only; no combinational path from any input.

Optional Feature:
- Macro STDOUT_FIFO_STATS_EN.
- Defined: adds outputs stat_bytes_written[31:0] (accepted pushes) and stat_bytes_dropped[31:0] (rejected pushes).
  - Both reset to 0 asynchronously.
  - Both saturate at 32'hFFFF_FFFF, never wrap.
  - Neither is affected by clear_overflow.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan (DEPTH_LOG2=2, ALMOST_FULL_MARGIN=1 unless noted):
- Reset then push 8'h41 -> next cycle read_ready=1, read_data=8'h41, level=1; pop -> next cycle read_ready=0, read_data=8'h00, level=0.
- Push 8'h01..8'h04 -> level=4, cpu_write_ready=0, almost_full=1 from level 3; push 8'h05 -> overflow=1, level=4; pops return 01,02,03,04 in order, 05 never appears.
- Fill to 4, then push 8'hAA and pop in the same cycle -> 8'h01 is popped, level stays 4, overflow stays 0; draining yields 02,03,04,AA.
- Push/pop 1 byte per cycle for 10 cycles (pointer wrap) with data i -> each byte is read back intact in order; level never exceeds 1.
- Set overflow, assert clear_overflow alone -> overflow=0 next cycle; reset_n low while level=3 -> level=0, read_ready=0 within the same cycle.
- With STDOUT_FIFO_STATS_EN: 5 pushes into an empty depth-4 FIFO with no pops -> stat_bytes_written=4, stat_bytes_dropped=1.
